// File: rtl/ble_in_route_rx_if.sv
// Bundle of configuration-chain and routing-wire signals for ble_in_route_rx.
// master drives the chain and the wires; slave is the routing block.
interface ble_in_route_rx_if #(
    parameter int NUM_IN = 4
);
    logic              cfg_en;
    logic              cfg_din;
    logic              cfg_dout;
    logic              cfg_commit;
    logic              cfg_reject;
    logic              cfg_valid;
    logic [NUM_IN-1:0] left_in;
    logic [NUM_IN-1:0] up_in;
    logic [NUM_IN-1:0] right_in;
    logic [NUM_IN-1:0] down_in;
    logic [NUM_IN-1:0] ble_in;
    logic              route_err;

    modport master (
        output cfg_en, cfg_din, cfg_commit, left_in, up_in, right_in, down_in,
        input  cfg_dout, cfg_reject, cfg_valid, ble_in, route_err
    );

    modport slave (
        input  cfg_en, cfg_din, cfg_commit, left_in, up_in, right_in, down_in,
        output cfg_dout, cfg_reject, cfg_valid, ble_in, route_err
    );
endinterface

// File: rtl/ble_in_route_rx.sv
// Receive-side BLE input routing switch with a serial shadow/active mask chain.
// Define ROUTE_CONFLICT_CHK_EN to build the sticky multi-hot mask detector (route_err).
module ble_in_route_rx #(
    parameter int NUM_IN = 4
) (
    input logic              clk,
    input logic              rst,
    ble_in_route_rx_if.slave bus
);
    localparam int CFG_W = 4 * NUM_IN;
    localparam int CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);

    typedef enum logic [1:0] {
        UNCFG,
        LOAD,
        FULL
    } state_e;

    state_e            state_q, state_d;
    logic [CFG_W-1:0]  shadow_q, shadow_d;
    logic [CFG_W-1:0]  active_q, active_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic              reject_q, reject_d;
    logic [NUM_IN-1:0] ble_q, ble_d;
    logic              commit_ok;

    // Fixed priority left > up > right > down; an all-zero mask leaves the input at 0.
    function automatic logic route_sel(input logic [3:0] mask, input logic l, input logic u,
                                       input logic r, input logic d);
        if (mask[0])      return l;
        else if (mask[1]) return u;
        else if (mask[2]) return r;
        else if (mask[3]) return d;
        else              return 1'b0;
    endfunction

    always_comb begin
        // NOTE: every _d gets a default first so no path through this block infers a latch.
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        count_d  = count_q;
        valid_d  = valid_q;

        commit_ok = bus.cfg_commit && !bus.cfg_en && (state_q == FULL);
        reject_d  = bus.cfg_commit && !commit_ok;

        if (bus.cfg_en) begin
            shadow_d = {shadow_q[CFG_W-2:0], bus.cfg_din};
            count_d  = (count_q == CNT_FULL) ? CNT_FULL : count_q + CNT_W'(1);
            state_d  = (count_d == CNT_FULL) ? FULL : LOAD;
        end

        // A commit only lands when no shift competes with it, so active never sees a partial word.
        if (commit_ok) begin
            active_d = shadow_q;
            valid_d  = 1'b1;
            count_d  = '0;
            state_d  = UNCFG;
        end

        for (int i = 0; i < NUM_IN; i++) begin
            ble_d[i] = valid_q && route_sel(active_q[4*i +: 4], bus.left_in[i], bus.up_in[i],
                                            bus.right_in[i], bus.down_in[i]);
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= UNCFG;
            shadow_q <= '0;
            active_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            reject_q <= 1'b0;
            ble_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            reject_q <= reject_d;
            ble_q    <= ble_d;
        end
    end

`ifdef ROUTE_CONFLICT_CHK_EN
    logic err_q, err_d;

    // Sticky: only reset clears it, a later clean commit leaves it set.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < NUM_IN; i++) begin
            if (valid_q && ((active_q[4*i +: 4] & (active_q[4*i +: 4] - 4'd1)) != 4'd0)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign bus.route_err = err_q;
`else
    assign bus.route_err = 1'b0;
`endif

    assign bus.cfg_dout   = shadow_q[CFG_W-1];
    assign bus.cfg_reject = reject_q;
    assign bus.cfg_valid  = valid_q;
    assign bus.ble_in     = ble_q;
endmodule

// File: tb/tb_ble_in_route_rx.sv
// Scoreboard bench for ble_in_route_rx: a cycle model pushes expected outputs per
// driven cycle, popped and compared one clock later, plus directed checks.
module tb_ble_in_route_rx;
    localparam int NUM_IN = 4;
    localparam int CFG_W  = 4 * NUM_IN;

`ifdef ROUTE_CONFLICT_CHK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] ble;
        logic       valid;
        logic       reject;
        logic       dout;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ble_in_route_rx_if #(.NUM_IN(NUM_IN)) bus ();
    ble_in_route_rx #(.NUM_IN(NUM_IN)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    exp_t sb_q[$];

    logic [15:0] m_shadow, m_active;
    int          m_count;
    logic        m_valid, m_err;
    logic [3:0]  w_l, w_u, w_r, w_d;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic en, input logic din, input logic commit, output exp_t e);
        logic [15:0] sh_n, act_n;
        int          cnt_n;
        logic        val_n, ok, err_n;
        logic [3:0]  ble_n, mask, wv;
        sh_n  = m_shadow;
        act_n = m_active;
        cnt_n = m_count;
        val_n = m_valid;
        err_n = m_err;
        ok    = commit && !en && (m_count == CFG_W);
        if (en) begin
            sh_n  = {m_shadow[14:0], din};
            cnt_n = (m_count < CFG_W) ? m_count + 1 : CFG_W;
        end
        if (ok) begin
            act_n = m_shadow;
            val_n = 1'b1;
            cnt_n = 0;
        end
        for (int i = 0; i < NUM_IN; i++) begin
            mask = m_active[4*i +: 4];
            wv   = {w_d[i], w_r[i], w_u[i], w_l[i]};
            ble_n[i] = 1'b0;
            // Scan down to bit 0 so the lowest set direction is the one left standing.
            for (int k = 3; k >= 0; k--) begin
                if (mask[k]) ble_n[i] = wv[k];
            end
            if (!m_valid) ble_n[i] = 1'b0;
            if (ERR_ON && m_valid && ($countones(mask) > 1)) err_n = 1'b1;
        end
        m_shadow = sh_n;
        m_active = act_n;
        m_count  = cnt_n;
        m_valid  = val_n;
        m_err    = err_n;
        e = '{ble: ble_n, valid: val_n, reject: commit && !ok, dout: sh_n[15], err: err_n};
    endtask

    task automatic cycle(input logic en, input logic din, input logic commit);
        exp_t e;
        @(negedge clk);
        bus.cfg_en     = en;
        bus.cfg_din    = din;
        bus.cfg_commit = commit;
        bus.left_in    = w_l;
        bus.up_in      = w_u;
        bus.right_in   = w_r;
        bus.down_in    = w_d;
        model_step(en, din, commit, e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 16'd1, 16'd0);
        end else begin
            e = sb_q.pop_front();
            check("ble_in", 16'(bus.ble_in), 16'(e.ble));
            check("cfg_valid", 16'(bus.cfg_valid), 16'(e.valid));
            check("cfg_reject", 16'(bus.cfg_reject), 16'(e.reject));
            check("cfg_dout", 16'(bus.cfg_dout), 16'(e.dout));
            check("route_err", 16'(bus.route_err), 16'(e.err));
        end
    endtask

    task automatic shift_bits(input logic [15:0] word, input int n, input logic commit_last);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, word[15-i], commit_last && (i == n - 1));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_ble_in", 16'(bus.ble_in), 16'd0);
        check("rst_valid", 16'(bus.cfg_valid), 16'd0);
        check("rst_reject", 16'(bus.cfg_reject), 16'd0);
        check("rst_dout", 16'(bus.cfg_dout), 16'd0);
        check("rst_err", 16'(bus.route_err), 16'd0);
        m_shadow = '0;
        m_active = '0;
        m_count  = 0;
        m_valid  = 1'b0;
        m_err    = 1'b0;
        sb_q.delete();
        bus.cfg_en     = 1'b0;
        bus.cfg_din    = 1'b0;
        bus.cfg_commit = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        w_l = '0; w_u = '0; w_r = '0; w_d = '0;
        bus.cfg_en = 1'b0; bus.cfg_din = 1'b0; bus.cfg_commit = 1'b0;
        bus.left_in = '0; bus.up_in = '0; bus.right_in = '0; bus.down_in = '0;
        #3;
        do_reset();

        // All wires high but nothing committed: outputs stay quiet.
        w_l = 4'hf; w_u = 4'hf; w_r = 4'hf; w_d = 4'hf;
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        check("uncfg_ble_in", 16'(bus.ble_in), 16'd0);

        // Partial load rejected, completion accepted.
        shift_bits(16'h8421, 10, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        check("partial_reject", 16'(bus.cfg_reject), 16'd1);
        check("partial_valid", 16'(bus.cfg_valid), 16'd0);
        cycle(1'b0, 1'b0, 1'b0);
        check("reject_one_cycle", 16'(bus.cfg_reject), 16'd0);
        // Counter was cleared only by a good commit, so 6 more bits fill the chain.
        shift_bits(16'h8421 << 10, 6, 1'b0);
        w_l = 4'b0001; w_u = 4'b0010; w_r = 4'b0100; w_d = 4'b1000;
        cycle(1'b0, 1'b0, 1'b1);
        check("commit_valid", 16'(bus.cfg_valid), 16'd1);
        cycle(1'b0, 1'b0, 1'b0);
        check("route_8421", 16'(bus.ble_in), 16'hf);

        for (int i = 0; i < 8; i++) begin
            w_l = 4'($urandom); w_u = 4'($urandom); w_r = 4'($urandom); w_d = 4'($urandom);
            cycle(1'b0, 1'b0, 1'b0);
        end

        // Commit on the 16th shift is refused; old routing holds until the retry.
        w_l = 4'b0001; w_u = 4'b0010; w_r = 4'b0100; w_d = 4'b1000;
        shift_bits(16'h0000, 16, 1'b1);
        check("same_cycle_reject", 16'(bus.cfg_reject), 16'd1);
        cycle(1'b0, 1'b0, 1'b0);
        check("old_route_kept", 16'(bus.ble_in), 16'hf);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check("route_0000", 16'(bus.ble_in), 16'd0);

        // Chain-out delay: a lone leading 1 reaches cfg_dout after the 16th shift.
        shift_bits(16'h8000, 15, 1'b0);
        check("dout_before_16", 16'(bus.cfg_dout), 16'd0);
        cycle(1'b1, 1'b0, 1'b0);
        check("dout_at_16", 16'(bus.cfg_dout), 16'd1);

        // Multi-hot mask on input 0: left beats up.
        w_l = 4'b0000; w_u = 4'b0001; w_r = 4'b0000; w_d = 4'b0000;
        shift_bits(16'h0003, 16, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check("multihot_left_wins", 16'(bus.ble_in[0]), 16'd0);
        check("route_err_set", 16'(bus.route_err), 16'(ERR_ON));
        shift_bits(16'h8421, 16, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        check("route_err_sticky", 16'(bus.route_err), 16'(ERR_ON));

        // Random masks and wires exercise the priority order on every input.
        for (int j = 0; j < 4; j++) begin
            shift_bits(16'($urandom), 16, 1'b0);
            cycle(1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 4; i++) begin
                w_l = 4'($urandom); w_u = 4'($urandom); w_r = 4'($urandom); w_d = 4'($urandom);
                cycle(1'b0, 1'b0, 1'b0);
            end
        end

        // Reset while routing is live, then reset mid-shift at count 7.
        do_reset();
        cycle(1'b0, 1'b0, 1'b0);
        shift_bits(16'hffff, 7, 1'b0);
        #2;
        do_reset();
        cycle(1'b0, 1'b0, 1'b0);
        check("post_rst_dout", 16'(bus.cfg_dout), 16'd0);
        // After reset the chain starts empty again, so 9 more bits cannot commit.
        shift_bits(16'hffff, 9, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        check("post_rst_reject", 16'(bus.cfg_reject), 16'd1);
        shift_bits(16'hffff, 7, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/ble_in_route_rx.md
Name: ble_in_route_rx

Overview:
- Receive-side routing switch for a BLE. It takes the four directional routing wires (left/up/right/down) arriving at each BLE input and selects one of them.
- Each input is routed according to a 4-bit direction mask per input. The mask encoding is identical to the BLE-output direction select: bit0 left, bit1 up, bit2 right, bit3 down.
- Masks are loaded through a serial configuration chain into a shadow register. They are committed atomically to an active register.
- Selected values are registered before driving the BLE inputs.

Parameters:
- NUM_IN, 4, number of BLE inputs routed by this block.
- CFG_W, 4*NUM_IN, configuration chain length in bits (derived; do not override).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- cfg_en  input  1  shift one config bit this cycle.
- cfg_din  input  1  serial config data in, MSB of the chain first.
- cfg_dout  output  1  serial chain out = shadow[CFG_W-1], for daisy-chaining.
- cfg_commit  input  1  request to copy shadow to active.
- cfg_reject  output  1  one-cycle pulse when a commit is refused.
- cfg_valid  output  1  high once any commit has succeeded since reset.
- left_in  input  NUM_IN  left wire per BLE input.
- up_in  input  NUM_IN  up wire per BLE input.
- right_in  input  NUM_IN  right wire per BLE input.
- down_in  input  NUM_IN  down wire per BLE input.
- ble_in  output  NUM_IN  registered routed value per BLE input.
- route_err  output  1  sticky multi-hot mask flag (optional feature).

Behaviour:
- Reset (async, rst=1):
  - shadow, active, bit counter and ble_in all clear to 0.
  - cfg_valid=0, cfg_reject=0, route_err=0.
  - FSM goes to UNCFG.
- Shift: on cfg_en=1, shadow <= {shadow[CFG_W-2:0], cfg_din}.
  - The bit counter increments and saturates at CFG_W.
  - The first bit shifted ends in shadow[CFG_W-1] after CFG_W shifts.
  - cfg_dout is registered, so the chain-out delay is CFG_W cycles.
- Mask layout: active[4i+3:4i] is the mask for BLE input i.
- FSM states and transitions:
  - UNCFG: no bits shifted since reset or last commit. cfg_en goes to LOAD.
  - LOAD: 0 < count < CFG_W. cfg_en moves to FULL when count reaches CFG_W.
  - FULL: count == CFG_W. Further cfg_en shifts the data but stays in FULL.
- Commit:
  - cfg_commit in FULL with cfg_en=0: active <= shadow next edge, cfg_valid <= 1, count <= 0, FSM goes to UNCFG.
  - cfg_commit in UNCFG or LOAD, or in the same cycle as cfg_en=1: the shift still occurs, the commit is ignored, and cfg_reject pulses 1 the next cycle.
- Reloading while cfg_valid=1: active keeps routing unchanged until the next successful commit. There is no glitch or partial update.
- Routing (one-cycle latency), registered per input i each cycle:
  - cfg_valid=0: ble_in[i] <= 0.
  - mask 0000: ble_in[i] <= 0 (unconnected input).
  - one-hot mask: ble_in[i] <= the selected wire.
  - multi-hot mask: fixed priority left > up > right > down.
- A commit changes routing starting with the edge after the active update. Total latency is 2 cycles from the commit cycle.
- Reset mid-load or mid-operation discards the shadow and active contents. The block must be fully reloaded.

Optional Feature:
- Macro ROUTE_CONFLICT_CHK_EN.
- Defined: route_err is set (sticky) on the edge after any committed active mask is multi-hot. It is cleared only by rst; a later clean commit does not clear it.
- Undefined: route_err is tied 0 and no conflict logic is built. Priority resolution is unchanged.

Test Plan:
- Reset, then drive all wires to 1 with no commit → ble_in=0000, cfg_valid=0, cfg_reject=0.
- Shift 16'h8421 MSB-first (16 cycles), then commit. Set left_in=0001, up_in=0010, right_in=0100, down_in=1000 → cfg_valid=1, ble_in=1111 two cycles after commit. Toggling each wire is reflected 1 cycle later.
- Shift only 10 bits, then commit → cfg_reject pulses for one cycle, cfg_valid stays 0, active is unchanged. Shift 6 more bits, then commit → accepted.
- With active=16'h8421, shift 16'h0000 and assert commit on the same cycle as the 16th cfg_en → reject pulse. The old routing persists. Commit next cycle → ble_in=0000.
- Commit mask 4'b0011 on input 0 with left=0, up=1 → ble_in[0]=0 (left wins). With ROUTE_CONFLICT_CHK_EN, route_err=1 and stays 1 after a clean commit. Without it, route_err=0.
- Assert rst mid-shift (count=7) and while routing active → all outputs are 0 immediately (async), FSM is UNCFG, and cfg_dout=0.
